vball_color_arb: RTL and testbench

VBALL_COLOR_ARB -- requirements
Module: vball_color_arb

---
 rtl/vball_color_arb.sv | 101 ++++++++++
 tb/tb_vball_color_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vball_color_arb.sv
`default_nettype none
// ============================================================================
// vball_color_arb - color RAM port arbiter (bg > cpu/sprite round-robin). Rev 1.0
// ============================================================================
module vball_color_arb #(
  parameter int AW = 11,
  parameter int DW = 12
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          bg_req,
  input  logic [AW-1:0] bg_addr,
  output logic          bg_gnt,
  output logic          bg_rvalid,
  input  logic          sp_req,
  input  logic [AW-1:0] sp_addr,
  output logic          sp_gnt,
  output logic          sp_rvalid,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          col_busy,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BG   = 2'd1,
    OWN_SP   = 2'd2
  } owner_t;

  owner_t own_s1;
  owner_t own_next;
  logic   rr_cpu;
  logic   contended;

  // Background is pixel-timed and always wins; CPU and sprite share the rest.
  always_comb begin
    bg_gnt  = 1'b0;
    sp_gnt  = 1'b0;
    cpu_gnt = 1'b0;
    if (reset_n) begin
      if (bg_req) begin
        bg_gnt = 1'b1;
      end else if (cpu_req && sp_req) begin
        if (rr_cpu) cpu_gnt = 1'b1;
        else        sp_gnt  = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (sp_req) begin
        sp_gnt = 1'b1;
      end
    end
  end

  assign contended = reset_n & ~bg_req & cpu_req & sp_req;

  always_comb begin
    own_next = OWN_NONE;
    if (bg_gnt)      own_next = OWN_BG;
    else if (sp_gnt) own_next = OWN_SP;
  end

  // Second owner stage lives in the one-hot rvalid flops, aligned with ram_dout.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rr_cpu    <= 1'b1;
      own_s1    <= OWN_NONE;
      bg_rvalid <= 1'b0;
      sp_rvalid <= 1'b0;
      col_busy  <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      if (contended) rr_cpu <= ~rr_cpu;
      own_s1    <= own_next;
      bg_rvalid <= (own_s1 == OWN_BG);
      sp_rvalid <= (own_s1 == OWN_SP);
      col_busy  <= bg_req | cpu_gnt;
      ram_we    <= cpu_gnt;
      if (bg_gnt) begin
        ram_addr <= bg_addr;
      end else if (sp_gnt) begin
        ram_addr <= sp_addr;
      end else if (cpu_gnt) begin
        ram_addr <= cpu_addr;
        ram_din  <= cpu_wdata;
      end
    end
  end

  assign rdata = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_vball_color_arb.sv
`default_nettype none
// ============================================================================
// tb_vball_color_arb - directed bench with a synchronous color RAM model. Rev 1.0
// ============================================================================
module tb_vball_color_arb;
  localparam int AW = 11;
  localparam int DW = 12;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          bg_req, sp_req, cpu_req;
  logic [AW-1:0] bg_addr, sp_addr, cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          bg_gnt, sp_gnt, cpu_gnt;
  logic          bg_rvalid, sp_rvalid, col_busy, ram_we;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  vball_color_arb #(.AW(AW), .DW(DW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_gnt(bg_gnt), .bg_rvalid(bg_rvalid),
    .sp_req(sp_req), .sp_addr(sp_addr), .sp_gnt(sp_gnt), .sp_rvalid(sp_rvalid),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .col_busy(col_busy), .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [31:0] t;
    t = {21'b0, a} * 32'd7 + 32'd3;
    return t[DW-1:0];
  endfunction

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic          written [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_din;
      written[ram_addr] <= 1'b1;
    end
    ram_dout <= (written[ram_addr] === 1'b1) ? mem[ram_addr] : pat(ram_addr);
  end

  task automatic idle_inputs;
    bg_req = 1'b0; sp_req = 1'b0; cpu_req = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge clk_sys); #1;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset;
    reset_n = 1'b0; bg_req = 1'b1; sp_req = 1'b1; cpu_req = 1'b1;
    bg_addr = 11'h155; sp_addr = 11'h2AA; cpu_addr = 11'h3CC; cpu_wdata = 12'hFFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++; if (bg_gnt !== 1'b0) $display("FAIL rst_bg_gnt c%0d: got %b want 0", k, bg_gnt); else pass_cnt++;
      total_cnt++; if (sp_gnt !== 1'b0) $display("FAIL rst_sp_gnt c%0d: got %b want 0", k, sp_gnt); else pass_cnt++;
      total_cnt++; if (cpu_gnt !== 1'b0) $display("FAIL rst_cpu_gnt c%0d: got %b want 0", k, cpu_gnt); else pass_cnt++;
      if (k > 0) begin
        total_cnt++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we c%0d: got %b want 0", k, ram_we); else pass_cnt++;
        total_cnt++; if (ram_addr !== '0) $display("FAIL rst_ram_addr c%0d: got %h want 0", k, ram_addr); else pass_cnt++;
        total_cnt++; if (ram_din !== '0) $display("FAIL rst_ram_din c%0d: got %h want 0", k, ram_din); else pass_cnt++;
        total_cnt++; if (bg_rvalid !== 1'b0) $display("FAIL rst_bg_rvalid c%0d: got %b want 0", k, bg_rvalid); else pass_cnt++;
        total_cnt++; if (sp_rvalid !== 1'b0) $display("FAIL rst_sp_rvalid c%0d: got %b want 0", k, sp_rvalid); else pass_cnt++;
        total_cnt++; if (col_busy !== 1'b0) $display("FAIL rst_col_busy c%0d: got %b want 0", k, col_busy); else pass_cnt++;
      end
      @(posedge clk_sys); #1;
    end
    reset_n = 1'b1;
    drain(3);
  endtask

  task automatic test_bg_priority;
    for (int k = 0; k <= 10; k++) begin
      if (k < 8) begin
        bg_req = 1'b1; bg_addr = AW'(32'h400 + k); sp_req = 1'b1; sp_addr = 11'h123;
      end else begin
        idle_inputs();
      end
      #1;
      if (k < 8) begin
        total_cnt++; if (bg_gnt !== 1'b1) $display("FAIL bg_gnt c%0d: got %b want 1", k, bg_gnt); else pass_cnt++;
        total_cnt++; if (sp_gnt !== 1'b0) $display("FAIL bg_sp_gnt c%0d: got %b want 0", k, sp_gnt); else pass_cnt++;
      end
      total_cnt++; if (col_busy !== (k >= 1 && k <= 8)) $display("FAIL bg_col_busy c%0d: got %b want %b", k, col_busy, (k >= 1 && k <= 8)); else pass_cnt++;
      total_cnt++; if (bg_rvalid !== (k >= 2 && k <= 9)) $display("FAIL bg_rvalid c%0d: got %b want %b", k, bg_rvalid, (k >= 2 && k <= 9)); else pass_cnt++;
      total_cnt++; if (sp_rvalid !== 1'b0) $display("FAIL bg_sp_rvalid c%0d: got %b want 0", k, sp_rvalid); else pass_cnt++;
      if (k >= 1 && k <= 8) begin
        total_cnt++; if (ram_addr !== AW'(32'h400 + k - 1)) $display("FAIL bg_ram_addr c%0d: got %h want %h", k, ram_addr, AW'(32'h400 + k - 1)); else pass_cnt++;
      end
      if (k >= 2 && k <= 9) begin
        total_cnt++; if (rdata !== pat(AW'(32'h400 + k - 2))) $display("FAIL bg_rdata c%0d: got %h want %h", k, rdata, pat(AW'(32'h400 + k - 2))); else pass_cnt++;
      end
      next_cycle();
    end
    drain(2);
  endtask

  task automatic test_contention;
    logic exp_cpu, exp_sp, exp_we, exp_sv;
    for (int k = 0; k <= 8; k++) begin
      if (k < 6) begin
        cpu_req = 1'b1; cpu_addr = AW'(32'h600 + k); cpu_wdata = DW'(32'h100 + k);
        sp_req = 1'b1; sp_addr = AW'(32'h700 + k);
      end else begin
        idle_inputs();
      end
      #1;
      exp_cpu = (k < 6) && (k % 2 == 0);
      exp_sp  = (k < 6) && (k % 2 == 1);
      total_cnt++; if (cpu_gnt !== exp_cpu) $display("FAIL rr_cpu_gnt c%0d: got %b want %b", k, cpu_gnt, exp_cpu); else pass_cnt++;
      total_cnt++; if (sp_gnt !== exp_sp) $display("FAIL rr_sp_gnt c%0d: got %b want %b", k, sp_gnt, exp_sp); else pass_cnt++;
      if (k >= 1) begin
        exp_we = (k - 1 < 6) && ((k - 1) % 2 == 0);
        total_cnt++; if (ram_we !== exp_we) $display("FAIL rr_ram_we c%0d: got %b want %b", k, ram_we, exp_we); else pass_cnt++;
        total_cnt++; if (col_busy !== exp_we) $display("FAIL rr_col_busy c%0d: got %b want %b", k, col_busy, exp_we); else pass_cnt++;
        if (k - 1 < 6) begin
          total_cnt++;
          if (ram_addr !== (exp_we ? AW'(32'h600 + k - 1) : AW'(32'h700 + k - 1)))
            $display("FAIL rr_ram_addr c%0d: got %h want %h", k, ram_addr, (exp_we ? AW'(32'h600 + k - 1) : AW'(32'h700 + k - 1)));
          else pass_cnt++;
        end
        if (exp_we) begin
          total_cnt++; if (ram_din !== DW'(32'h100 + k - 1)) $display("FAIL rr_ram_din c%0d: got %h want %h", k, ram_din, DW'(32'h100 + k - 1)); else pass_cnt++;
        end
      end
      exp_sv = (k >= 2) && (k - 2 < 6) && ((k - 2) % 2 == 1);
      total_cnt++; if (sp_rvalid !== exp_sv) $display("FAIL rr_sp_rvalid c%0d: got %b want %b", k, sp_rvalid, exp_sv); else pass_cnt++;
      if (exp_sv) begin
        total_cnt++; if (rdata !== pat(AW'(32'h700 + k - 2))) $display("FAIL rr_rdata c%0d: got %h want %h", k, rdata, pat(AW'(32'h700 + k - 2))); else pass_cnt++;
      end
      next_cycle();
    end
    drain(2);
  endtask

  task automatic test_write_then_read;
    for (int k = 0; k <= 4; k++) begin
      idle_inputs();
      if (k == 0) begin cpu_req = 1'b1; cpu_addr = 11'h512; cpu_wdata = 12'hABC; end
      if (k == 1) begin sp_req = 1'b1; sp_addr = 11'h512; end
      #1;
      if (k == 0) begin
        total_cnt++; if (cpu_gnt !== 1'b1) $display("FAIL wr_cpu_gnt c%0d: got %b want 1", k, cpu_gnt); else pass_cnt++;
      end
      if (k == 1) begin
        total_cnt++; if (sp_gnt !== 1'b1) $display("FAIL wr_sp_gnt c%0d: got %b want 1", k, sp_gnt); else pass_cnt++;
        total_cnt++; if (ram_din !== 12'hABC) $display("FAIL wr_ram_din c%0d: got %h want abc", k, ram_din); else pass_cnt++;
      end
      if (k == 1 || k == 2) begin
        total_cnt++; if (ram_addr !== 11'h512) $display("FAIL wr_ram_addr c%0d: got %h want 512", k, ram_addr); else pass_cnt++;
      end
      if (k >= 1) begin
        total_cnt++; if (ram_we !== (k == 1)) $display("FAIL wr_ram_we c%0d: got %b want %b", k, ram_we, (k == 1)); else pass_cnt++;
      end
      total_cnt++; if (sp_rvalid !== (k == 3)) $display("FAIL wr_sp_rvalid c%0d: got %b want %b", k, sp_rvalid, (k == 3)); else pass_cnt++;
      if (k == 3) begin
        total_cnt++; if (rdata !== 12'hABC) $display("FAIL wr_rdata c%0d: got %h want abc", k, rdata); else pass_cnt++;
      end
      next_cycle();
    end
    drain(2);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k <= 6; k++) begin
      idle_inputs();
      if (k < 4) begin sp_req = 1'b1; sp_addr = AW'(32'h050 + k); end
      #1;
      total_cnt++; if (sp_gnt !== (k < 4)) $display("FAIL b2b_sp_gnt c%0d: got %b want %b", k, sp_gnt, (k < 4)); else pass_cnt++;
      total_cnt++; if (sp_rvalid !== (k >= 2 && k <= 5)) $display("FAIL b2b_sp_rvalid c%0d: got %b want %b", k, sp_rvalid, (k >= 2 && k <= 5)); else pass_cnt++;
      total_cnt++; if (bg_rvalid !== 1'b0) $display("FAIL b2b_bg_rvalid c%0d: got %b want 0", k, bg_rvalid); else pass_cnt++;
      if (k >= 2 && k <= 5) begin
        total_cnt++; if (rdata !== pat(AW'(32'h050 + k - 2))) $display("FAIL b2b_rdata c%0d: got %h want %h", k, rdata, pat(AW'(32'h050 + k - 2))); else pass_cnt++;
      end
      next_cycle();
    end
    drain(2);
  endtask

  task automatic test_reset_inflight;
    idle_inputs();
    sp_req = 1'b1; sp_addr = 11'h077;
    #1;
    total_cnt++; if (sp_gnt !== 1'b1) $display("FAIL inf_sp_gnt: got %b want 1", sp_gnt); else pass_cnt++;
    next_cycle();
    reset_n = 1'b0;
    #1;
    total_cnt++; if (sp_gnt !== 1'b0) $display("FAIL inf_gnt_in_reset: got %b want 0", sp_gnt); else pass_cnt++;
    total_cnt++; if (ram_addr !== 11'h077) $display("FAIL inf_ram_addr_pre: got %h want 077", ram_addr); else pass_cnt++;
    next_cycle();
    reset_n = 1'b1; idle_inputs();
    #1;
    total_cnt++; if (ram_addr !== '0) $display("FAIL inf_ram_addr: got %h want 0", ram_addr); else pass_cnt++;
    total_cnt++; if (ram_din !== '0) $display("FAIL inf_ram_din: got %h want 0", ram_din); else pass_cnt++;
    total_cnt++; if (ram_we !== 1'b0) $display("FAIL inf_ram_we: got %b want 0", ram_we); else pass_cnt++;
    total_cnt++; if (col_busy !== 1'b0) $display("FAIL inf_col_busy: got %b want 0", col_busy); else pass_cnt++;
    total_cnt++; if (bg_rvalid !== 1'b0) $display("FAIL inf_bg_rvalid: got %b want 0", bg_rvalid); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (sp_rvalid !== 1'b0) $display("FAIL inf_sp_rvalid c%0d: got %b want 0", k, sp_rvalid); else pass_cnt++;
      next_cycle();
      #1;
    end
    drain(1);
  endtask

  task automatic test_drop_without_grant;
    for (int k = 0; k <= 4; k++) begin
      idle_inputs();
      if (k == 0) begin bg_req = 1'b1; bg_addr = 11'h010; sp_req = 1'b1; sp_addr = 11'h3FF; end
      if (k == 1) begin bg_req = 1'b1; bg_addr = 11'h011; end
      #1;
      total_cnt++; if (sp_gnt !== 1'b0) $display("FAIL drop_sp_gnt c%0d: got %b want 0", k, sp_gnt); else pass_cnt++;
      total_cnt++; if (sp_rvalid !== 1'b0) $display("FAIL drop_sp_rvalid c%0d: got %b want 0", k, sp_rvalid); else pass_cnt++;
      total_cnt++; if (bg_rvalid !== (k == 2 || k == 3)) $display("FAIL drop_bg_rvalid c%0d: got %b want %b", k, bg_rvalid, (k == 2 || k == 3)); else pass_cnt++;
      if (k >= 1) begin
        total_cnt++; if (ram_we !== 1'b0) $display("FAIL drop_ram_we c%0d: got %b want 0", k, ram_we); else pass_cnt++;
        total_cnt++;
        if (ram_addr !== ((k == 1) ? 11'h010 : 11'h011))
          $display("FAIL drop_ram_addr c%0d: got %h want %h", k, ram_addr, ((k == 1) ? 11'h010 : 11'h011));
        else pass_cnt++;
      end
      next_cycle();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    bg_addr = '0; sp_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_bg_priority();
    test_contention();
    test_write_then_read();
    test_back_to_back();
    test_reset_inflight();
    test_drop_without_grant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
